// File: rtl/fp16_divider_if.sv
// Operand/result handshake bundle for the fp16 divider.
// The requester drives operands and accepts results; the divider computes.
interface fp16_divider_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/fp16_divider.sv
// IEEE binary16 divider: radix-2 restoring division of the significands,
// round-to-nearest-even, subnormals flushed to zero, with a valid/ready handshake.
module fp16_divider (
    input  logic          CLK,
    input  logic          RESETn,
    fp16_divider_if.slave bus
);
    localparam int unsigned EXP_W   = 5;
    localparam int unsigned MAN_W   = 10;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned Q_W     = 13;
    localparam int unsigned REM_W   = SIG_W + 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned E_W     = 8;
    localparam int unsigned LAST_Q  = Q_W - 1;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [Q_W-1:0]          q;
    logic [REM_W-1:0]        rem;
    logic [SIG_W-1:0]        dvs;
    logic signed [E_W-1:0]   exp_d;
    logic                    sign;
    logic [15:0]             res;
    logic [15:0]             out_q;
    logic                    out_valid_q;
    logic                    in_ready_q;

    logic [EXP_W-1:0]        ea_c, eb_c;
    logic [MAN_W-1:0]        ma_c, mb_c;
    logic                    special_c;
    logic [14:0]             spec_mag_c;
    logic                    accept_c;

    logic                    q_bit_c;
    logic [REM_W-1:0]        rem_sel_c;

    logic [MAN_W-1:0]        frac_c;
    logic                    rnd_c, stk_c, inc_c;
    logic [MAN_W:0]          sum_c;
    logic signed [E_W-1:0]   e_c;
    logic [14:0]             round_mag_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    assign ea_c     = bus.A[14:10];
    assign eb_c     = bus.B[14:10];
    assign ma_c     = bus.A[9:0];
    assign mb_c     = bus.B[9:0];
    assign accept_c = (state == IDLE) && bus.in_valid && in_ready_q;

    // Operand classification and special-case magnitudes
    always_comb begin
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        nan_a      = (ea_c == 5'd31) && (ma_c != '0);
        nan_b      = (eb_c == 5'd31) && (mb_c != '0);
        inf_a      = (ea_c == 5'd31) && (ma_c == '0);
        inf_b      = (eb_c == 5'd31) && (mb_c == '0);
        zero_a     = (ea_c == '0);
        zero_b     = (eb_c == '0);
        special_c  = 1'b1;
        spec_mag_c = 15'h0000;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            spec_mag_c = 15'h7C01;
        else if (zero_b || inf_a)
            spec_mag_c = 15'h7C00;
        else if (zero_a || inf_b)
            spec_mag_c = 15'h0000;
        else
            special_c = 1'b0;
    end

    // One restoring-division step
    always_comb begin
        q_bit_c   = (rem >= {1'b0, dvs});
        rem_sel_c = q_bit_c ? (rem - {1'b0, dvs}) : rem;
    end

    // Normalization and round-to-nearest-even on the finished quotient
    always_comb begin
        if (q[LAST_Q]) begin
            frac_c = q[11:2];
            rnd_c  = q[1];
            stk_c  = q[0] | (rem != '0);
            e_c    = exp_d + 8'sd15;
        end else begin
            frac_c = q[10:1];
            rnd_c  = q[0];
            stk_c  = (rem != '0);
            e_c    = exp_d + 8'sd14;
        end
        inc_c = rnd_c & (stk_c | frac_c[0]);
        sum_c = {1'b0, frac_c} + (MAN_W+1)'(inc_c);
        if (sum_c[MAN_W])
            e_c = e_c + 8'sd1;
        if (e_c >= 8'sd31)
            round_mag_c = 15'h7C00;
        else if (e_c <= 8'sd0)
            round_mag_c = 15'h0000;
        else
            round_mag_c = {e_c[EXP_W-1:0], sum_c[MAN_W-1:0]};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = special_c ? DONE : DIV;
            DIV:     if (cnt == CNT_W'(LAST_Q)) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt         <= '0;
            q           <= '0;
            rem         <= '0;
            dvs         <= '0;
            exp_d       <= '0;
            sign        <= 1'b0;
            res         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            in_ready_q <= (state_nx == IDLE);
            case (state)
                IDLE: if (accept_c) begin
                    sign  <= bus.A[15] ^ bus.B[15];
                    res   <= {bus.A[15] ^ bus.B[15], spec_mag_c};
                    rem   <= {2'b01, ma_c};
                    dvs   <= {1'b1, mb_c};
                    exp_d <= $signed({3'b000, ea_c}) - $signed({3'b000, eb_c});
                    cnt   <= '0;
                    q     <= '0;
                end
                DIV: begin
                    q   <= {q[LAST_Q-1:0], q_bit_c};
                    rem <= {rem_sel_c[REM_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                ROUND: res <= {sign, round_mag_c};
                DONE: begin
                    if (!out_valid_q) begin
                        out_q       <= res;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_divider.sv
// Directed-vector bench for fp16_divider: results, latency, backpressure and reset abort.
module tb_fp16_divider;
    logic CLK;
    logic RESETn;
    fp16_divider_if bus();

    fp16_divider dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, want);
        end
    endtask

    // Issue one operation, then measure latency and result; A/B are scrambled after acceptance.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want, input int lat, input string nm);
        int n;
        bit rdy;
        @(negedge CLK);
        rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin rdy = 1'b1; break; end
            @(negedge CLK);
        end
        check({nm, "_ready"}, 32'(rdy), 32'd1);
        bus.A = a; bus.B = b; bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0; bus.A = 16'hFFFF; bus.B = 16'h1234;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check({nm, "_lat"}, 32'(n), 32'(lat));
        check({nm, "_out"}, 32'(bus.out), 32'(want));
        if (bus.out_ready) begin
            @(posedge CLK); #1;
            check({nm, "_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h4000, 16'h3C00, 16'h4000, 15, "two_by_one"};
        vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 15, "one_by_three"};
        vecs[2]  = '{16'hC000, 16'h4000, 16'hBC00, 15, "neg_two_by_two"};
        vecs[3]  = '{16'h3C00, 16'h3C00, 16'h3C00, 15, "one_by_one"};
        vecs[4]  = '{16'h3C00, 16'h4000, 16'h3800, 15, "half"};
        vecs[5]  = '{16'h4500, 16'h4000, 16'h4100, 15, "five_by_two"};
        vecs[6]  = '{16'h3F00, 16'h3D00, 16'h3D9A, 15, "round_up"};
        vecs[7]  = '{16'h4000, 16'h4200, 16'h3955, 15, "two_by_three"};
        vecs[8]  = '{16'h7BFF, 16'h3800, 16'h7C00, 15, "overflow"};
        vecs[9]  = '{16'h0400, 16'h7BFF, 16'h0000, 15, "underflow"};
        vecs[10] = '{16'h3C00, 16'h0000, 16'h7C00, 1,  "div_zero"};
        vecs[11] = '{16'h0000, 16'h0000, 16'h7C01, 1,  "zero_zero"};
        vecs[12] = '{16'h7E00, 16'h3C00, 16'h7C01, 1,  "nan_a"};
        vecs[13] = '{16'h3C00, 16'h7C00, 16'h0000, 1,  "fin_inf"};
        vecs[14] = '{16'h7C00, 16'h7C00, 16'h7C01, 1,  "inf_inf"};
        vecs[15] = '{16'hFC00, 16'h3C00, 16'hFC00, 1,  "ninf_fin"};
        vecs[16] = '{16'h3C00, 16'h8000, 16'hFC00, 1,  "div_negzero"};
        vecs[17] = '{16'h0200, 16'h3C00, 16'h0000, 1,  "subnorm_flush"};

        bus.A = 16'h0; bus.B = 16'h0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        RESETn = 1'b0;
        #12;
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge CLK); RESETn = 1'b1;
        @(negedge CLK);
        check("rst_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // Backpressure: result held, inputs ignored, then back-to-back acceptance
        bus.out_ready = 1'b0;
        run_op(16'h4000, 16'h3C00, 16'h4000, 15, "bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            bus.A = 16'($urandom); bus.B = 16'($urandom); bus.in_valid = 1'b1;
            @(posedge CLK); #1;
            check("bp_hold_out", 32'(bus.out), 32'h4000);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge CLK);
        bus.out_ready = 1'b1; bus.A = 16'h3C00; bus.B = 16'h4200; bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        begin
            int n;
            @(posedge CLK); #1;
            bus.in_valid = 1'b0;
            n = 0;
            while (!bus.out_valid && n < 40) begin
                @(posedge CLK); #1;
                n++;
            end
            check("bp_next_lat", 32'(n), 32'd15);
            check("bp_next_out", 32'(bus.out), 32'h3555);
            @(posedge CLK); #1;
        end

        // Reset mid-division aborts; next operation runs at full latency
        @(negedge CLK);
        bus.A = 16'h4500; bus.B = 16'h4000; bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RESETn = 1'b0;
        #1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out", 32'(bus.out), 32'h0);
        @(negedge CLK); RESETn = 1'b1;
        repeat (20) begin
            @(posedge CLK); #1;
            if (bus.out_valid) break;
        end
        check("abort_no_result", 32'(bus.out_valid), 32'd0);
        run_op(16'hC000, 16'h4000, 16'hBC00, 15, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
